// File: rtl/monitor_pkg.sv
// Shared types and default constants for the store result monitor and its bench.
package monitor_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PASS    = 3'd2,
        FAIL    = 3'd3,
        TIMEOUT = 3'd4
    } mon_state_t;

    localparam logic [31:0] DEF_RESULT_ADDR = 32'd108;
    localparam logic [31:0] DEF_EXPECTED    = 32'h0000FE0B;
    localparam int          DEF_TIMEOUT_CYC = 1000;

    // Terminal states freeze counters and ignore the bus.
    function automatic logic is_verdict(input mon_state_t s);
        return (s == PASS) || (s == FAIL) || (s == TIMEOUT);
    endfunction

endpackage

// File: rtl/store_log.sv
// Circular log of the most recent stores; index 0 reads the newest entry.
module store_log #(
    parameter int LOG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_data,
    input  logic [LOG_AW-1:0] i_rd_idx,
    output logic [31:0]       o_rd_addr,
    output logic [31:0]       o_rd_data,
    output logic [LOG_AW:0]   o_count
);

    localparam int              DEPTH = 1 << LOG_AW;
    localparam logic [LOG_AW:0] FULL  = {1'b1, {LOG_AW{1'b0}}};

    logic [LOG_AW-1:0] r_wr_ptr;
    logic [LOG_AW:0]   r_count;
    logic [31:0]       r_addr_mem [DEPTH];
    logic [31:0]       r_data_mem [DEPTH];
    logic [LOG_AW-1:0] w_rd_ptr;
    logic              w_rd_valid;

    // Write pointer and fill level; clear empties the log, full pushes overwrite the oldest.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_push) begin
            r_wr_ptr <= r_wr_ptr + {{(LOG_AW-1){1'b0}}, 1'b1};
            if (r_count != FULL) begin
                r_count <= r_count + {{LOG_AW{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage needs no reset: reads beyond the fill level are forced to zero.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) begin
            r_addr_mem[r_wr_ptr] <= i_addr;
            r_data_mem[r_wr_ptr] <= i_data;
        end
    end

    // Newest entry sits at wr_ptr-1, so idx maps to wr_ptr-1-idx == wr_ptr + ~idx.
    always_comb begin
        w_rd_ptr   = r_wr_ptr + ~i_rd_idx;
        w_rd_valid = ({1'b0, i_rd_idx} < r_count);
        o_rd_addr  = w_rd_valid ? r_addr_mem[w_rd_ptr] : 32'd0;
        o_rd_data  = w_rd_valid ? r_data_mem[w_rd_ptr] : 32'd0;
    end

    assign o_count = r_count;

endmodule

// File: rtl/store_result_monitor.sv
// Bus checker: counts RUN cycles and stores, logs stores, and latches a
// PASS/FAIL/TIMEOUT verdict from the first store to RESULT_ADDR.
module store_result_monitor
    import monitor_pkg::*;
#(
    parameter logic [31:0] RESULT_ADDR = DEF_RESULT_ADDR,
    parameter logic [31:0] EXPECTED    = DEF_EXPECTED,
    parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int          CW          = 32,
    parameter int          LOG_AW      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              memwrite,
    input  logic [31:0]       dataadr,
    input  logic [31:0]       writedata,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CW-1:0]     cycles,
    output logic [15:0]       store_count,
    output logic [31:0]       bad_data,
    input  logic [LOG_AW-1:0] log_rd_idx,
    output logic [31:0]       log_rd_addr,
    output logic [31:0]       log_rd_data,
    output logic [LOG_AW:0]   log_count
);

    localparam logic [CW-1:0] CYC_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CYC_ONE  = CW'(1);

    mon_state_t    r_state;
    mon_state_t    w_state_nxt;
    logic [CW-1:0] r_cycles;
    logic [15:0]   r_store_count;
    logic [31:0]   r_bad_data;
    logic          w_run;
    logic          w_store;
    logic          w_hit;
    logic          w_match;

    // start outranks any same-edge store, so a restart never logs or counts it.
    assign w_run   = (r_state == RUN);
    assign w_store = w_run && !start && memwrite;
    assign w_hit   = w_store && (dataadr == RESULT_ADDR);
    assign w_match = (writedata == EXPECTED);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a result store on the timeout edge beats the timeout.
    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = RUN;
        end else if (w_run) begin
            if (w_hit) begin
                w_state_nxt = w_match ? PASS : FAIL;
            end else if (r_cycles == CYC_LAST) begin
                w_state_nxt = TIMEOUT;
            end
        end
    end

    // RUN cycle counter, saturating, frozen once a verdict is reached.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycles <= '0;
        end else if (start) begin
            r_cycles <= '0;
        end else if (w_run && (r_cycles != {CW{1'b1}})) begin
            r_cycles <= r_cycles + CYC_ONE;
        end
    end

    // Saturating count of stores observed during RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_store_count <= '0;
        end else if (start) begin
            r_store_count <= '0;
        end else if (w_store && (r_store_count != 16'hFFFF)) begin
            r_store_count <= r_store_count + 16'd1;
        end
    end

    // Capture the data of a mismatching result store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bad_data <= '0;
        end else if (start) begin
            r_bad_data <= '0;
        end else if (w_hit && !w_match) begin
            r_bad_data <= writedata;
        end
    end

    store_log #(
        .LOG_AW (LOG_AW)
    ) u_store_log (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (start),
        .i_push    (w_store),
        .i_addr    (dataadr),
        .i_data    (writedata),
        .i_rd_idx  (log_rd_idx),
        .o_rd_addr (log_rd_addr),
        .o_rd_data (log_rd_data),
        .o_count   (log_count)
    );

    // Status outputs decode only registered state.
    assign done        = is_verdict(r_state);
    assign pass        = (r_state == PASS);
    assign fail        = (r_state == FAIL);
    assign timeout     = (r_state == TIMEOUT);
    assign cycles      = r_cycles;
    assign store_count = r_store_count;
    assign bad_data    = r_bad_data;

endmodule

// File: tb/tb_store_result_monitor.sv
// Scoreboard bench for store_result_monitor: a cycle-level reference model
// pushes verdict expectations that are checked when done rises.
module tb_store_result_monitor;
    import monitor_pkg::*;

    localparam int          TO  = 20;
    localparam logic [31:0] RA  = DEF_RESULT_ADDR;
    localparam logic [31:0] EV  = DEF_EXPECTED;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = 32'd0;
    logic [31:0] writedata = 32'd0;
    logic [2:0]  log_rd_idx = 3'd0;
    logic        done, pass, fail, timeout;
    logic [31:0] cycles;
    logic [15:0] store_count;
    logic [31:0] bad_data, log_rd_addr, log_rd_data;
    logic [3:0]  log_count;

    store_result_monitor #(
        .RESULT_ADDR (RA),
        .EXPECTED    (EV),
        .TIMEOUT_CYC (TO),
        .CW          (32),
        .LOG_AW      (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .memwrite    (memwrite),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .cycles      (cycles),
        .store_count (store_count),
        .bad_data    (bad_data),
        .log_rd_idx  (log_rd_idx),
        .log_rd_addr (log_rd_addr),
        .log_rd_data (log_rd_data),
        .log_count   (log_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        p;
        logic        f;
        logic        t;
        logic [31:0] cyc;
        logic [31:0] sc;
        logic [31:0] bad;
        logic [31:0] lc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_la[$];
    logic [31:0] m_ld[$];
    logic        m_run = 1'b0;
    logic        m_done = 1'b0;
    int          m_cyc = 0;
    int          m_sc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_lc();
        return (m_la.size() > 8) ? 32'd8 : 32'(m_la.size());
    endfunction

    task automatic model_clear();
        m_cyc = 0;
        m_sc  = 0;
        m_la.delete();
        m_ld.delete();
        m_done = 1'b0;
    endtask

    // One clock: drive at negedge, sample 1 ns after the rising edge.
    task automatic t_step(input logic st, input logic we, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        start = st; memwrite = we; dataadr = a; writedata = d;
        @(posedge clk);
        #1;
        if (st) begin
            model_clear();
            m_run = 1'b1;
        end else if (m_run) begin
            m_cyc++;
            if (we) begin
                m_sc++;
                m_la.push_front(a);
                m_ld.push_front(d);
                if (m_la.size() > 8) begin
                    void'(m_la.pop_back());
                    void'(m_ld.pop_back());
                end
            end
            if (we && a == RA) begin
                m_run = 1'b0; m_done = 1'b1;
                e.p = (d == EV); e.f = (d != EV); e.t = 1'b0;
                e.bad = (d == EV) ? 32'd0 : d;
                e.cyc = 32'(m_cyc); e.sc = 32'(m_sc); e.lc = m_lc();
                exp_q.push_back(e);
            end else if (m_cyc == TO) begin
                m_run = 1'b0; m_done = 1'b1;
                e.p = 1'b0; e.f = 1'b0; e.t = 1'b1; e.bad = 32'd0;
                e.cyc = 32'(m_cyc); e.sc = 32'(m_sc); e.lc = m_lc();
                exp_q.push_back(e);
            end
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("verdict_done", 32'(done), 32'd1);
            chk("verdict_pass", 32'(pass), 32'(e.p));
            chk("verdict_fail", 32'(fail), 32'(e.f));
            chk("verdict_timeout", 32'(timeout), 32'(e.t));
            chk("verdict_cycles", cycles, e.cyc);
            chk("verdict_store_count", 32'(store_count), e.sc);
            chk("verdict_bad_data", bad_data, e.bad);
            chk("verdict_log_count", 32'(log_count), e.lc);
        end else begin
            chk("done", 32'(done), 32'(m_done));
            chk("cycles", cycles, 32'(m_cyc));
            chk("store_count", 32'(store_count), 32'(m_sc));
            chk("log_count", 32'(log_count), m_lc());
        end
        start = 1'b0; memwrite = 1'b0;
    endtask

    // Walk all log indices; only call while the monitor is not in RUN.
    task automatic check_log(input string tag);
        logic [31:0] ea, ed;
        for (int i = 0; i < 8; i++) begin
            log_rd_idx = 3'(i);
            #1;
            ea = (i < m_la.size()) ? m_la[i] : 32'd0;
            ed = (i < m_ld.size()) ? m_ld[i] : 32'd0;
            chk({tag, "_addr"}, log_rd_addr, ea);
            chk({tag, "_data"}, log_rd_data, ed);
        end
        log_rd_idx = 3'd0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_fail"}, 32'(fail), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_cycles"}, cycles, 32'd0);
        chk({tag, "_store_count"}, 32'(store_count), 32'd0);
        chk({tag, "_bad_data"}, bad_data, 32'd0);
        chk({tag, "_log_count"}, 32'(log_count), 32'd0);
        chk({tag, "_log_addr"}, log_rd_addr, 32'd0);
    endtask

    initial begin
        #2;
        check_zero("por");
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;

        // Reset in the middle of a run abandons it.
        t_step(1'b1, 1'b0, 32'd0, 32'd0);
        t_step(1'b0, 1'b1, 32'h10, 32'h11);
        t_step(1'b0, 1'b1, 32'h14, 32'h22);
        #2 reset = 1'b0;
        #1 check_zero("rst_mid");
        m_run = 1'b0; model_clear(); exp_q.delete();
        #1 reset = 1'b1;
        t_step(1'b0, 1'b1, RA, EV);
        t_step(1'b0, 1'b1, 32'h20, 32'h5);
        chk("idle_state", 32'(dut.r_state), 32'(IDLE));

        // Two ordinary stores then a matching result store.
        t_step(1'b1, 1'b0, 32'd0, 32'd0);
        t_step(1'b0, 1'b1, 32'h50, 32'd7);
        t_step(1'b0, 1'b1, 32'h54, 32'd3);
        t_step(1'b0, 1'b1, RA, EV);
        chk("t2_pass", 32'(pass), 32'd1);
        check_log("t2_log");
        log_rd_idx = 3'd2; #1;
        chk("t2_idx2_addr", log_rd_addr, 32'h50);
        log_rd_idx = 3'd0;

        // Mismatching result store; a later correct one is ignored.
        t_step(1'b1, 1'b0, 32'd0, 32'd0);
        t_step(1'b0, 1'b1, RA, 32'h0000FE0A);
        t_step(1'b0, 1'b1, RA, EV);
        chk("t3_fail_hold", 32'(fail), 32'd1);
        chk("t3_pass_hold", 32'(pass), 32'd0);
        chk("t3_bad_data", bad_data, 32'h0000FE0A);
        check_log("t3_log");
        t_step(1'b1, 1'b0, 32'd0, 32'd0);
        chk("t3_bad_clear", bad_data, 32'd0);

        // Timeout with no stores, bounded wait.
        for (int i = 0; i < 40 && !done; i++) t_step(1'b0, 1'b0, 32'd0, 32'd0);
        chk("t4_timeout_seen", 32'(timeout), 32'd1);
        chk("t4_cycles", cycles, 32'(TO));

        // Result store on the timeout edge wins.
        t_step(1'b1, 1'b0, 32'd0, 32'd0);
        repeat (TO - 1) t_step(1'b0, 1'b0, 32'd0, 32'd0);
        t_step(1'b0, 1'b1, RA, EV);
        chk("t4b_pass", 32'(pass), 32'd1);
        chk("t4b_timeout", 32'(timeout), 32'd0);

        // Log wrap: ten stores plus the result store.
        t_step(1'b1, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 10; i++) t_step(1'b0, 1'b1, 32'(i * 4), 32'(32'h100 + i));
        t_step(1'b0, 1'b1, RA, EV);
        chk("t5_log_count", 32'(log_count), 32'd8);
        check_log("t5_log");
        log_rd_idx = 3'd7; #1;
        chk("t5_idx7_addr", log_rd_addr, 32'h0C);
        log_rd_idx = 3'd0;

        // start beats a same-edge store, from PASS and from RUN.
        t_step(1'b1, 1'b1, RA, EV);
        chk("t6_state_run", 32'(dut.r_state), 32'(RUN));
        t_step(1'b0, 1'b1, 32'h40, 32'd5);
        t_step(1'b1, 1'b1, 32'h44, 32'd6);
        chk("t6_restart_sc", 32'(store_count), 32'd0);
        t_step(1'b0, 1'b0, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
